// File: rtl/seq_divider_16.sv
// seq_divider_16
// Iterative unsigned divider using restoring trial subtraction. It produces
// one quotient bit per clock, so a nonzero divide takes WIDTH cycles from
// acceptance to the done pulse.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        request a division; ignored while busy
//   dividend     numerator, captured when start is accepted
//   divisor      denominator, captured when start is accepted
//   busy         high while iterating
//   done         single-cycle pulse; results are valid in that cycle
//   quotient     unsigned quotient, held until the next result
//   remainder    unsigned remainder, held until the next result
//   div_by_zero  set with done when the divisor was zero; cleared by the next accepted start
module seq_divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   part_rem;
  logic [WIDTH-1:0] dvd_shift;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] q_shift;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;

  // One restoring-division step. The trial difference is formed as
  // P + ~D + 1 at WIDTH+1 bits. Because P is always below 2*divisor, the
  // top bit of the difference is set exactly when it went negative.
  always_comb begin
    shifted = {part_rem[WIDTH-1:0], dvd_shift[WIDTH-1]};
    trial   = shifted + ~{1'b0, dvsr} + {{WIDTH{1'b0}}, 1'b1};
    if (!trial[WIDTH]) begin
      p_next = trial;
      q_next = {q_shift[WIDTH-2:0], 1'b1};
    end else begin
      p_next = shifted;
      q_next = {q_shift[WIDTH-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and status decode. A start seen in the DONE cycle is
  // accepted just as it would be from IDLE, so divides can issue back to back.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_iter  = (count == CW'(1));
    case (state)
      IDLE, DONE: begin
        done       = (state == DONE);
        accept     = start;
        state_next = IDLE;
        if (start) state_next = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers. The results are written on the edge that ends the
  // last iteration, so they are already valid during the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      part_rem    <= '0;
      dvd_shift   <= '0;
      dvsr        <= '0;
      q_shift     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvd_shift <= dividend;
      dvsr      <= divisor;
      part_rem  <= '0;
      q_shift   <= '0;
      if (divisor == '0) begin
        count       <= '0;
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        count       <= CW'(WIDTH);
        div_by_zero <= 1'b0;
      end
    end else if (state == RUN) begin
      part_rem  <= p_next;
      dvd_shift <= {dvd_shift[WIDTH-2:0], 1'b0};
      q_shift   <= q_next;
      count     <= count - CW'(1);
      if (last_iter) begin
        quotient  <= q_next;
        remainder <= p_next[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_16.sv
// tb_seq_divider_16
// Self-checking bench for seq_divider_16. Each issued divide pushes its
// expected result (computed with the simulator's own / and % operators) into
// a scoreboard queue. The entry is popped and compared when done is observed.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_seq_divider_16;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  exp_t sb[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  seq_divider_16 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference model: pushes the expected result for a divide.
  task automatic push_expected(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 16'd0) e = '{q: 16'hFFFF, r: a, z: 1'b1};
    else            e = '{q: a / b, r: a % b, z: 1'b0};
    sb.push_back(e);
  endtask

  // Drives start for exactly one edge. Call it at a falling edge. It returns
  // at the falling edge of the first cycle after the capture edge (T+1).
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    push_expected(a, b);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Waits for done while counting busy cycles. The current cycle is k=1.
  // cycles is 0 when the budget expires.
  task automatic wait_done(input int budget, output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    for (int k = 1; k <= budget; k++) begin
      if (done) begin
        cycles = k;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_compared++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b q=%h r=%h z=%b want all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic();
    int   cyc, bcyc;
    exp_t e, got;
    issue(16'd100, 16'd7);
    wait_done(40, cyc, bcyc);
    n_compared++;
    if (cyc !== 17) begin
      n_mismatched++;
      $display("[TB] FAIL basic_latency: got done at T+%0d want T+17", cyc);
    end
    n_compared++;
    if (bcyc !== 16 || busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL basic_busy: got %0d busy cycles, busy=%b at done, want 16 and 0", bcyc, busy);
    end
    e   = sb.pop_front();
    got = '{q: quotient, r: remainder, z: div_by_zero};
    n_compared++;
    if (got !== e || e.q !== 16'd14 || e.r !== 16'd2) begin
      n_mismatched++;
      $display("[TB] FAIL basic_result: got q=%0d r=%0d z=%b want q=14 r=2 z=0", got.q, got.r, got.z);
    end
    @(negedge clk);
    n_compared++;
    if (done !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL basic_pulse: got done=%b one cycle later want 0", done);
    end
    repeat (10) @(negedge clk);
    n_compared++;
    if (quotient !== 16'd14 || remainder !== 16'd2 || busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL basic_hold: got q=%0d r=%0d busy=%b want 14 2 0", quotient, remainder, busy);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc, bcyc;
    exp_t e, got;
    issue(16'hFFFF, 16'h0001);
    wait_done(40, cyc, bcyc);
    e   = sb.pop_front();
    got = '{q: quotient, r: remainder, z: div_by_zero};
    n_compared++;
    if (cyc !== 17 || got !== e) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_first: got T+%0d q=%h r=%h z=%b want T+17 q=%h r=%h z=%b",
               cyc, got.q, got.r, got.z, e.q, e.r, e.z);
    end
    // Issue the next divide in the DONE cycle itself.
    issue(16'h0003, 16'h000A);
    wait_done(40, cyc, bcyc);
    e   = sb.pop_front();
    got = '{q: quotient, r: remainder, z: div_by_zero};
    n_compared++;
    if (cyc !== 17 || bcyc !== 16) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_latency: got T+%0d busy=%0d want T+17 busy=16", cyc, bcyc);
    end
    n_compared++;
    if (got !== e) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_second: got q=%h r=%h z=%b want q=%h r=%h z=%b",
               got.q, got.r, got.z, e.q, e.r, e.z);
    end
    @(negedge clk);
  endtask

  task automatic test_div_by_zero();
    int   cyc, bcyc;
    exp_t e, got;
    issue(16'd5, 16'd0);
    wait_done(40, cyc, bcyc);
    e   = sb.pop_front();
    got = '{q: quotient, r: remainder, z: div_by_zero};
    n_compared++;
    if (cyc !== 1 || bcyc !== 0 || busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL dbz_timing: got T+%0d busy_cycles=%0d want T+1 and 0", cyc, bcyc);
    end
    n_compared++;
    if (got !== e) begin
      n_mismatched++;
      $display("[TB] FAIL dbz_result: got q=%h r=%h z=%b want q=%h r=%h z=%b",
               got.q, got.r, got.z, e.q, e.r, e.z);
    end
    @(negedge clk);
    issue(16'd9, 16'd3);
    wait_done(40, cyc, bcyc);
    e   = sb.pop_front();
    got = '{q: quotient, r: remainder, z: div_by_zero};
    n_compared++;
    if (cyc !== 17 || got !== e) begin
      n_mismatched++;
      $display("[TB] FAIL dbz_recover: got T+%0d q=%0d r=%0d z=%b want T+17 q=%0d r=%0d z=%b",
               cyc, got.q, got.r, got.z, e.q, e.r, e.z);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int   cyc, bcyc, extra;
    exp_t e, got;
    issue(16'd1000, 16'd10);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 16'd7;
    divisor  = 16'd7;
    @(negedge clk);
    start    = 1'b0;
    wait_done(40, cyc, bcyc);
    e   = sb.pop_front();
    got = '{q: quotient, r: remainder, z: div_by_zero};
    n_compared++;
    if (cyc + 4 !== 17) begin
      n_mismatched++;
      $display("[TB] FAIL busy_start_latency: got done at T+%0d want T+17", cyc + 4);
    end
    n_compared++;
    if (got !== e) begin
      n_mismatched++;
      $display("[TB] FAIL busy_start_result: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
               got.q, got.r, got.z, e.q, e.r, e.z);
    end
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_compared++;
    if (extra !== 0 || quotient !== 16'd100 || remainder !== 16'd0) begin
      n_mismatched++;
      $display("[TB] FAIL busy_start_single: got %0d extra done, q=%0d r=%0d want 0 extra, 100 0",
               extra, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid_op();
    int   cyc, bcyc, seen;
    exp_t e, got;
    issue(16'h8000, 16'h0003);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    n_compared++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_state: got busy=%b done=%b q=%h r=%h z=%b want all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_compared++;
    if (seen !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_quiet: got %0d busy/done cycles after reset want 0", seen);
    end
    issue(16'h8000, 16'h0003);
    wait_done(40, cyc, bcyc);
    e   = sb.pop_front();
    got = '{q: quotient, r: remainder, z: div_by_zero};
    n_compared++;
    if (cyc !== 17 || got !== e || e.q !== 16'h2AAA) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_fresh: got T+%0d q=%h r=%h z=%b want T+17 q=2aaa r=0002 z=0",
               cyc, got.q, got.r, got.z);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int          cyc, bcyc;
    exp_t        e, got;
    logic [15:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom);
      b = (i % 4 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom);
      issue(a, b);
      wait_done(40, cyc, bcyc);
      e   = sb.pop_front();
      got = '{q: quotient, r: remainder, z: div_by_zero};
      n_compared++;
      if (cyc === 0 || got !== e) begin
        n_mismatched++;
        $display("[TB] FAIL random_%0d: %h/%h got q=%h r=%h z=%b want q=%h r=%h z=%b",
                 i, a, b, got.q, got.r, got.z, e.q, e.r, e.z);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_by_zero();
    test_start_while_busy();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/seq_divider_16.md
Name: seq_divider_16

Overview:
- Iterative unsigned integer divider for the execute stage.
- Provides the inverse operation to the 16-bit carry-lookahead adder datapath: division by repeated trial subtraction.
- Each trial subtraction is done as A + ~B + 1, one quotient bit per cycle.
- Start/done handshake; the stall logic holds the pipeline while busy is high.

Parameters:
- WIDTH, 16, operand/quotient/remainder width in bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only when the unit is not busy.
- dividend  input  WIDTH  numerator; captured on an accepted start.
- divisor  input  WIDTH  denominator; captured on an accepted start.
- busy  output  1  high while iterating; start is ignored while busy.
- done  output  1  single-cycle pulse; results are valid from this cycle.
- quotient  output  WIDTH  unsigned quotient; held until the next accepted start.
- remainder  output  WIDTH  unsigned remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when divisor==0; held until the next accepted start.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
  - Reset overrides everything, including mid-operation: any in-flight division is abandoned and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge T: capture dividend/divisor.
  - If divisor!=0: go to RUN, clear partial remainder, load counter=WIDTH.
  - If divisor==0: go to DONE directly.
- RUN:
  - busy=1.
  - Each cycle: partial remainder P (WIDTH+1 bits) = {P[WIDTH-1:0], dividend_shift MSB}; dividend_shift shifts left by one.
  - Trial difference D = P + ~{1'b0,divisor} + 1, computed at WIDTH+1 bits.
  - If D[WIDTH]==0 (non-negative): P=D and the quotient bit is 1. Otherwise P is unchanged and the quotient bit is 0.
  - Quotient bits shift in LSB-first into the shift register, so the first iteration produces the MSB.
  - Counter decrements; when it reaches 0 after the WIDTH-th iteration, go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Output registers are updated so they are valid in this cycle.
  - Next state is IDLE, unless start=1 in this cycle: then a new operation is accepted exactly as from IDLE (back-to-back issue).
- Latency:
  - Start accepted at edge T with a nonzero divisor: busy=1 for cycles T+1..T+WIDTH; done=1 in cycle T+WIDTH+1 (T+17 for WIDTH=16).
  - Divide by zero: done=1 in cycle T+1, quotient=all ones, remainder=dividend, div_by_zero=1; busy never asserts.
- start while busy=1: ignored; captured operands are unaffected.
- Operand inputs may change freely after the capture edge without affecting the result.
- Results: quotient=floor(dividend/divisor), remainder=dividend mod divisor. Outputs stay stable between done pulses and after return to IDLE.
- Dividend < divisor: quotient=0, remainder=dividend; same latency as any nonzero divide (no early termination).
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- rst=1 for 2 cycles, then idle -> busy=0, done=0, quotient=0x0000, remainder=0x0000, div_by_zero=0.
- start with dividend=100, divisor=7 at edge T -> busy high T+1..T+16; done pulse at T+17 with quotient=14, remainder=2, div_by_zero=0; outputs still 14/2 ten cycles later.
- dividend=0xFFFF, divisor=0x0001 -> quotient=0xFFFF, remainder=0x0000. Then dividend=0x0003, divisor=0x000A issued in the DONE cycle -> accepted back-to-back; second done 17 cycles later with quotient=0, remainder=3.
- dividend=5, divisor=0 -> done at T+1, busy never high, quotient=0xFFFF, remainder=5, div_by_zero=1. A following 9/3 division -> div_by_zero clears, quotient=3, remainder=0.
- start 1000/10; pulse start with 7/7 at T+5 (busy) -> ignored; done at T+17 with quotient=100, remainder=0, and exactly one done pulse.
- start 0x8000/0x0003; assert rst at T+8 for 1 cycle -> all outputs 0, state IDLE, no done pulse; a fresh 0x8000/3 afterwards -> quotient=0x2AAA, remainder=2.
